// File: rtl/muldiv_unit_if.sv
// EX-stage <-> multiply/divide unit signal bundle.
// master = pipeline side, slave = muldiv_unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic [1:0]       aluop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush_i;
  logic             stall_o;
  logic             busy_o;
  logic             md_sel;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output valid_i, aluop, funct, a, b, flush_i,
    input  stall_o, busy_o, md_sel, rdata, hi_o, lo_o
  );
  modport slave (
    input  valid_i, aluop, funct, a, b, flush_i,
    output stall_o, busy_o, md_sel, rdata, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MIPS multiply/divide unit with HI/LO registers.
// Define MDU_DIV_EN to build the restoring divider; otherwise div/divu are no-ops.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           rst_n,
  muldiv_unit_if.slave  bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MUL   = 2'd1;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
`ifdef MDU_DIV_EN
  localparam logic [1:0] S_DIV   = 2'd2;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn & v[WIDTH-1]) ? -v : v;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, op_q, op_d;
  logic             neg_q, neg_d;

  logic is_r, is_mul, is_div, is_mf, is_mt, md_access, busy, sgn, start;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_p, mul_res;

  assign is_r      = bus.valid_i & (bus.aluop == 2'b10);
  assign is_mul    = is_r & ((bus.funct == F_MULT) | (bus.funct == F_MULTU));
  assign is_mf     = is_r & ((bus.funct == F_MFHI) | (bus.funct == F_MFLO));
  assign is_mt     = is_r & ((bus.funct == F_MTHI) | (bus.funct == F_MTLO));
`ifdef MDU_DIV_EN
  assign is_div    = is_r & ((bus.funct == F_DIV) | (bus.funct == F_DIVU));
`else
  assign is_div    = 1'b0;
`endif
  assign md_access = is_mul | is_div | is_mf | is_mt;
  assign busy      = (state_q != S_IDLE);
  assign sgn       = ~bus.funct[0];
  assign start     = ~busy & ~bus.stall_o & ~bus.flush_i;

  assign bus.stall_o = md_access & busy;
  assign bus.busy_o  = busy;
  assign bus.md_sel  = is_mf;
  assign bus.rdata   = is_mf ? (bus.funct[1] ? lo_q : hi_q) : '0;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;

  // Shift-add: acc_hi accumulates, acc_lo holds the shrinking multiplier and
  // collects product low bits from the top.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, op_q} : '0);
  assign mul_p   = {mul_sum, acc_lo_q[WIDTH-1:1]};
  assign mul_res = neg_q ? -mul_p : mul_p;

`ifdef MDU_DIV_EN
  logic             negr_q, negr_d, dz_q, dz_d;
  logic [WIDTH:0]   div_tmp;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem, div_quo;

  // Restoring step: acc_hi is the partial remainder, acc_lo shifts dividend
  // bits out of the top and quotient bits in at the bottom.
  assign div_tmp = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge  = (div_tmp >= {1'b0, op_q});
  assign div_rem = div_ge ? WIDTH'(div_tmp - {1'b0, op_q}) : div_tmp[WIDTH-1:0];
  assign div_quo = {acc_lo_q[WIDTH-2:0], div_ge};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    op_d     = op_q;
    neg_d    = neg_q;
`ifdef MDU_DIV_EN
    negr_d   = negr_q;
    dz_d     = dz_q;
`endif
    case (state_q)
      S_MUL: begin
        if (bus.flush_i) state_d = S_IDLE;
        else begin
          {acc_hi_d, acc_lo_d} = mul_p;
          if (cnt_q == '0) begin
            {hi_d, lo_d} = mul_res;
            state_d      = S_IDLE;
          end else cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        if (bus.flush_i) state_d = S_IDLE;
        else begin
          acc_hi_d = div_rem;
          acc_lo_d = div_quo;
          if (cnt_q == '0) begin
            // Divide by zero keeps the raw all-ones quotient regardless of sign.
            lo_d    = (neg_q & ~dz_q) ? -div_quo : div_quo;
            hi_d    = negr_q ? -div_rem : div_rem;
            state_d = S_IDLE;
          end else cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: begin
        if (start) begin
          if (is_mul) begin
            state_d  = S_MUL;
            cnt_d    = CNT_W'(WIDTH-1);
            acc_hi_d = '0;
            acc_lo_d = mag(bus.b, sgn);
            op_d     = mag(bus.a, sgn);
            neg_d    = sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          end
`ifdef MDU_DIV_EN
          if (is_div) begin
            state_d  = S_DIV;
            cnt_d    = CNT_W'(WIDTH-1);
            acc_hi_d = '0;
            acc_lo_d = mag(bus.a, sgn);
            op_d     = mag(bus.b, sgn);
            neg_d    = sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            negr_d   = sgn & bus.a[WIDTH-1];
            dz_d     = (bus.b == '0);
          end
`endif
          if (is_mt) begin
            if (bus.funct[1]) lo_d = bus.a;
            else              hi_d = bus.a;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
`ifdef MDU_DIV_EN
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
`ifdef MDU_DIV_EN
      negr_q   <= negr_d;
      dz_q     <= dz_d;
`endif
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences,
// and random ops against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  muldiv_unit_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  typedef struct {
    logic [5:0]   f;
    logic [W-1:0] a, b, hi, lo;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bus.valid_i = v; bus.aluop = op; bus.funct = f; bus.a = a; bus.b = b;
  endtask

  function automatic bit is_divf(input logic [5:0] f);
    return (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Architectural result from plain arithmetic on the architectural state.
  task automatic ref_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint sa, sb;
    logic [63:0] p;
    hi = cur_hi; lo = cur_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      F_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      F_MULTU: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      F_DIV, F_DIVU: if (DIV_EN) begin
        if (b == '0)        begin lo = '1; hi = a; end
        else if (f == F_DIV) begin lo = W'(sa / sb); hi = W'(sa % sb); end
        else                begin lo = a / b; hi = a % b; end
      end
      F_MTHI: hi = a;
      F_MTLO: lo = a;
      default: ;
    endcase
  endtask

  task automatic run_arith(input string nm, input logic [5:0] f, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int n, exp_lat;
    exp_lat = (is_divf(f) && !DIV_EN) ? 0 : W;
    drive(1'b1, 2'b10, f, a, b);
    #1 check({nm, " stall_at_issue"}, 64'(bus.stall_o), 64'd0);
    step();
    drive(1'b0, 2'b10, f, $urandom, $urandom);
    n = 0;
    while (bus.busy_o && n < 200) begin step(); n++; end
    check({nm, " busy_cycles"}, 64'(n), 64'(exp_lat));
    check({nm, " hi"}, 64'(bus.hi_o), 64'(eh));
    check({nm, " lo"}, 64'(bus.lo_o), 64'(el));
    cur_hi = eh; cur_lo = el;
  endtask

  task automatic run_mt(input string nm, input logic [5:0] f, input logic [W-1:0] a);
    drive(1'b1, 2'b10, f, a, '0);
    step();
    drive(1'b0, 2'b00, '0, '0, '0);
    if (f == F_MTHI) cur_hi = a; else cur_lo = a;
    check({nm, " hi"}, 64'(bus.hi_o), 64'(cur_hi));
    check({nm, " lo"}, 64'(bus.lo_o), 64'(cur_lo));
  endtask

  initial begin
    logic [W-1:0] eh, el, ra, rb;
    logic [5:0] f;
    int n, bad;
    logic [5:0] ops[8] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO};

    vt[0] = '{F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vt[1] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[2] = '{F_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vt[3] = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[4] = '{F_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vt[5] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vt[6] = '{F_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vt[7] = '{F_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vt[8] = '{F_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vt[9] = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

    drive(1'b0, 2'b00, '0, '0, '0);
    bus.flush_i = 1'b0;
    #3;
    check("reset busy", 64'(bus.busy_o), 64'd0);
    check("reset hi", 64'(bus.hi_o), 64'd0);
    check("reset lo", 64'(bus.lo_o), 64'd0);
    check("reset stall", 64'(bus.stall_o), 64'd0);
    step(); rst_n = 1'b1; step();

    for (int i = 0; i < 10; i++) begin
      if (is_divf(vt[i].f) && !DIV_EN) begin eh = cur_hi; el = cur_lo; end
      else begin eh = vt[i].hi; el = vt[i].lo; end
      run_arith($sformatf("vec%0d", i), vt[i].f, vt[i].a, vt[i].b, eh, el);
    end

    run_mt("mthi", F_MTHI, 32'h12345678);
    run_mt("mtlo", F_MTLO, 32'hCAFEF00D);

    // mflo issued 5 cycles after mult stalls until the unit goes idle.
    drive(1'b1, 2'b10, F_MULT, 32'd3, 32'd5);
    step();
    drive(1'b0, 2'b00, '0, '0, '0);
    repeat (4) step();
    drive(1'b1, 2'b10, F_MFLO, '0, '0);
    n = 0; bad = 0;
    #1;
    while (bus.busy_o && n < 200) begin
      if (!bus.stall_o) bad++;
      step(); n++;
    end
    cur_hi = '0; cur_lo = 32'd15;
    check("mflo stall_drop", 64'(bad), 64'd0);
    check("mflo stall_cycles", 64'(n), 64'(W - 4));
    check("mflo stall_after", 64'(bus.stall_o), 64'd0);
    check("mflo md_sel", 64'(bus.md_sel), 64'd1);
    check("mflo rdata", 64'(bus.rdata), 64'd15);
    drive(1'b1, 2'b10, F_MFHI, '0, '0);
    #1 check("mfhi rdata", 64'(bus.rdata), 64'(cur_hi));
    drive(1'b1, 2'b10, F_ADD, '0, '0);
    #1 check("nonmd md_sel", 64'(bus.md_sel), 64'd0);
    check("nonmd rdata", 64'(bus.rdata), 64'd0);
    drive(1'b1, 2'b00, F_MFLO, '0, '0);
    #1 check("aluop00 md_sel", 64'(bus.md_sel), 64'd0);
    step();
    drive(1'b0, 2'b00, '0, '0, '0);

    // Flush mid-operation leaves HI/LO intact; the next mult runs clean.
    f = DIV_EN ? F_DIV : F_MULT;
    drive(1'b1, 2'b10, f, 32'd100, 32'd7);
    step();
    drive(1'b0, 2'b00, '0, '0, '0);
    repeat (9) step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    check("flush busy", 64'(bus.busy_o), 64'd0);
    check("flush hi", 64'(bus.hi_o), 64'(cur_hi));
    check("flush lo", 64'(bus.lo_o), 64'(cur_lo));
    ra = $urandom; rb = $urandom;
    ref_op(F_MULT, ra, rb, eh, el);
    run_arith("post_flush", F_MULT, ra, rb, eh, el);

    for (int i = 0; i < 40; i++) begin
      f = ops[$urandom_range(0, 7)];
      ra = pick(); rb = pick();
      if (f == F_MFHI || f == F_MFLO) begin
        drive(1'b1, 2'b10, f, ra, rb);
        #1 check($sformatf("rnd%0d md_sel", i), 64'(bus.md_sel), 64'd1);
        check($sformatf("rnd%0d rdata", i), 64'(bus.rdata), 64'((f == F_MFHI) ? cur_hi : cur_lo));
        step();
        drive(1'b0, 2'b00, '0, '0, '0);
      end else if (f == F_MTHI || f == F_MTLO) begin
        run_mt($sformatf("rnd%0d", i), f, ra);
      end else begin
        ref_op(f, ra, rb, eh, el);
        run_arith($sformatf("rnd%0d", i), f, ra, rb, eh, el);
      end
      repeat ($urandom_range(0, 2)) step();
    end

    // Asynchronous reset in the middle of a mult.
    run_mt("pre_rst_hi", F_MTHI, 32'hDEADBEEF);
    run_mt("pre_rst_lo", F_MTLO, 32'h0BADF00D);
    drive(1'b1, 2'b10, F_MULT, 32'd7, 32'd9);
    step();
    drive(1'b0, 2'b00, '0, '0, '0);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst busy", 64'(bus.busy_o), 64'd0);
    check("async_rst hi", 64'(bus.hi_o), 64'd0);
    check("async_rst lo", 64'(bus.lo_o), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst busy", 64'(bus.busy_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
